// File: rtl/daq_pkg.sv
// Shared definitions for the acquisition scheduler: FSM state encoding and
// the fixed byte values that appear in the TX stream.
package daq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      SELECT = 3'd2,
      REQ    = 3'd3,
      WAIT   = 3'd4,
      PUSH   = 3'd5
   } state_t;

   localparam logic [2:0] HEADER_TAG   = 3'b101;
   localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/sample_scheduler_prescaler.sv
// Sample-period prescaler: one registered tick every pre+1 cycles while
// enabled, held at zero (no ticks) while disabled.
module prescaler
   import daq_pkg::*;
#(
   parameter int PRE_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [PRE_W-1:0] pre,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_r;
   logic             tick_r;

   // Counter and tick register; >= guards against pre shrinking mid-count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (!en) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (cnt_r >= pre) begin
         cnt_r  <= '0;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + PRE_W'(1);
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/sample_scheduler.sv
// Frame scheduler: on each prescaler tick emits a header byte and then one
// byte per enabled acquisition module, lowest index first, into the TX FIFO.
module sample_scheduler
   import daq_pkg::*;
#(
   parameter int NMOD  = 5,
   parameter int PRE_W = 10,
   parameter int TMO   = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NMOD-1:0]     activemods,
   input  logic [PRE_W-1:0]    pre,
   output logic [NMOD-1:0]     mod_req,
   input  logic [NMOD-1:0]     mod_ack,
   input  logic [8*NMOD-1:0]   mod_data,
   output logic [7:0]          tx_data,
   output logic                tx_push,
   input  logic                tx_full,
   output logic                overrun,
   output logic                busy
);

   localparam int IDX_W = (NMOD > 1) ? $clog2(NMOD) : 1;
   localparam int TMO_W = $clog2(TMO + 1);
   localparam int HDR_W = (NMOD < 5) ? NMOD : 5;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

   state_t            state_r, state_s;
   logic [NMOD-1:0]   rem_r, rem_s;
   logic [IDX_W-1:0]  sel_r, sel_s;
   logic [7:0]        cap_r, cap_s;
   logic [TMO_W-1:0]  tmo_r, tmo_s;
   logic [NMOD-1:0]   mod_req_r, mod_req_s;
   logic [7:0]        tx_data_r, tx_data_s;
   logic              overrun_r, overrun_s;
   logic              busy_r;
   logic              push_s;
   logic              tick_s;
   logic [IDX_W-1:0]  pick_idx_s;
   logic              pick_found_s;
   logic [7:0]        hdr_s;

   prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (|activemods),
      .pre  (pre),
      .tick (tick_s)
   );

   // Lowest-index pick over the remaining mask, and the header byte.
   always_comb begin
      pick_found_s = |rem_r;
      pick_idx_s   = '0;
      for (int k = NMOD - 1; k >= 0; k--) begin
         pick_idx_s = rem_r[k] ? IDX_W'(k) : pick_idx_s;
      end
      hdr_s = {HEADER_TAG, 5'b00000};
      hdr_s[HDR_W-1:0] = activemods[HDR_W-1:0];
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s   = state_r;
      rem_s     = rem_r;
      sel_s     = sel_r;
      cap_s     = cap_r;
      tmo_s     = tmo_r;
      mod_req_s = '0;
      tx_data_s = tx_data_r;
      push_s    = 1'b0;
      overrun_s = overrun_r | (tick_s & (state_r != IDLE));
      case (state_r)
         IDLE: begin
            if (tick_s) begin
               state_s   = HEADER;
               rem_s     = activemods;
               tx_data_s = hdr_s;
            end else begin
               state_s   = IDLE;
            end
         end
         HEADER: begin
            push_s = ~tx_full;
            if (!tx_full) begin
               state_s = SELECT;
            end else begin
               state_s = HEADER;
            end
         end
         SELECT: begin
            if (pick_found_s) begin
               state_s   = REQ;
               sel_s     = pick_idx_s;
               mod_req_s = NMOD'(1) << pick_idx_s;
            end else begin
               state_s   = IDLE;
            end
         end
         REQ: begin
            state_s = WAIT;
            tmo_s   = '0;
         end
         WAIT: begin
            // Only the addressed module's ack is honoured.
            if (mod_ack[sel_r]) begin
               cap_s     = mod_data[32'(sel_r) * 8 +: 8];
               tx_data_s = mod_data[32'(sel_r) * 8 +: 8];
               state_s   = PUSH;
            end else if (tmo_r == TMO_LAST) begin
               cap_s     = TIMEOUT_BYTE;
               tx_data_s = TIMEOUT_BYTE;
               state_s   = PUSH;
            end else begin
               tmo_s     = tmo_r + TMO_W'(1);
            end
         end
         PUSH: begin
            push_s = ~tx_full;
            if (!tx_full) begin
               rem_s[sel_r] = 1'b0;
               state_s      = SELECT;
            end else begin
               state_s      = PUSH;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         rem_r     <= '0;
         sel_r     <= '0;
         cap_r     <= 8'h00;
         tmo_r     <= '0;
         mod_req_r <= '0;
         tx_data_r <= 8'h00;
         overrun_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         rem_r     <= rem_s;
         sel_r     <= sel_s;
         cap_r     <= cap_s;
         tmo_r     <= tmo_s;
         mod_req_r <= mod_req_s;
         tx_data_r <= tx_data_s;
         overrun_r <= overrun_s;
         busy_r    <= (state_s != IDLE);
      end
   end

   // The push strobe must see tx_full in the same cycle, so it stays combinational.
   assign tx_push = push_s;
   assign mod_req = mod_req_r;
   assign tx_data = tx_data_r;
   assign overrun = overrun_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: modules answer two cycles after their
// request unless silenced; pushed bytes and cycles are logged and compared.
module tb_sample_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  activemods;
   logic [9:0]  pre;
   logic [4:0]  mod_req;
   logic [4:0]  mod_ack;
   logic [39:0] mod_data;
   logic [7:0]  tx_data;
   logic        tx_push;
   logic        tx_full;
   logic        overrun;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] pb[$];
   int         pc[$];
   int         rq_cyc[$];
   int         full_push_cnt;
   int         multi_req_cnt;
   logic [4:0] silent;
   int         pend_cnt;
   int         pend_idx;
   logic       smp_busy;

   int e_cyc;
   int rel;
   logic seen;
   logic [7:0] exp_b[$];

   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   sample_scheduler #(.NMOD(5), .PRE_W(10), .TMO(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .activemods (activemods),
      .pre        (pre),
      .mod_req    (mod_req),
      .mod_ack    (mod_ack),
      .mod_data   (mod_data),
      .tx_data    (tx_data),
      .tx_push    (tx_push),
      .tx_full    (tx_full),
      .overrun    (overrun),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, then update the module ack model after posedge.
   task automatic cycle();
      @(negedge clk);
      smp_busy = busy;
      if (tx_push) begin
         pb.push_back(tx_data);
         pc.push_back(cyc);
         if (tx_full) full_push_cnt++;
      end
      if (mod_req != 5'b00000) begin
         rq_cyc.push_back(cyc);
         if (!$onehot(mod_req)) multi_req_cnt++;
         for (int i = 0; i < 5; i++) begin
            if (mod_req[i] && !silent[i]) begin
               pend_cnt = 2;
               pend_idx = i;
            end
         end
      end
      @(posedge clk);
      #1;
      mod_ack = 5'b00000;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) mod_ack[pend_idx] = 1'b1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_log();
      pb.delete();
      pc.delete();
      rq_cyc.delete();
      full_push_cnt = 0;
      multi_req_cnt = 0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      activemods = 5'b00000;
      tx_full    = 1'b0;
      mod_ack    = 5'b00000;
      pend_cnt   = 0;
      silent     = 5'b00000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_log();
   endtask

   function automatic logic [31:0] byte_at(input int i);
      return (i < pb.size()) ? 32'(pb[i]) : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] cyc_at(input int i);
      return (i < pc.size()) ? 32'(pc[i]) : 32'hDEAD_BEEF;
   endfunction

   initial begin
      rst        = 1'b1;
      activemods = 5'b00000;
      pre        = 10'd0;
      tx_full    = 1'b0;
      mod_ack    = 5'b00000;
      mod_data   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      silent     = 5'b00000;
      pend_cnt   = 0;
      pend_idx   = 0;
      clear_log();
      #12;
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_mod_req", 32'(mod_req), 32'd0);
      check("rst_tx_push", 32'(tx_push), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Periodic frames; a two-module frame keeps the FSM busy 12 cycles, so period 16.
      pre = 10'd15;
      clear_log();
      activemods = 5'b00101;
      e_cyc = cyc;
      run(62);
      activemods = 5'b00000;
      exp_b = '{8'hA5, 8'h11, 8'h33};
      check("per_count", 32'(pb.size()), 32'd9);
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < 3; b++) check("per_byte", byte_at(3 * f + b), 32'(exp_b[b]));
         check("per_hdr_cyc", cyc_at(3 * f), 32'(e_cyc + 17 + 16 * f));
         check("per_d0_cyc",  cyc_at(3 * f + 1), 32'(e_cyc + 22 + 16 * f));
      end
      check("per_overrun", 32'(overrun), 32'd0);
      check("per_onehot_req", 32'(multi_req_cnt), 32'd0);
      run(4);

      // Timeout with a stray ack from module 0 during WAIT.
      do_reset();
      pre = 10'd31;
      silent = 5'b00010;
      activemods = 5'b00010;
      e_cyc = cyc;
      run(40);
      mod_ack = 5'b00001;
      run(16);
      activemods = 5'b00000;
      check("tmo_count",   32'(pb.size()), 32'd2);
      check("tmo_hdr",     byte_at(0), 32'h0000_00A2);
      check("tmo_ff",      byte_at(1), 32'h0000_00FF);
      check("tmo_hdr_cyc", cyc_at(0), 32'(e_cyc + 33));
      check("tmo_req_cyc", (rq_cyc.size() > 0) ? 32'(rq_cyc[0]) : 32'hDEAD_BEEF, 32'(e_cyc + 35));
      check("tmo_ff_cyc",  cyc_at(1), 32'(e_cyc + 51));
      check("tmo_overrun", 32'(overrun), 32'd0);

      // Backpressure on the header.
      do_reset();
      pre = 10'd63;
      tx_full = 1'b1;
      activemods = 5'b00001;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         cycle();
         seen = smp_busy;
      end
      check("bp_busy_seen", 32'(seen), 32'd1);
      run(19);
      check("bp_no_push_full", 32'(pb.size()), 32'd0);
      tx_full = 1'b0;
      rel = cyc;
      run(20);
      activemods = 5'b00000;
      check("bp_hdr",        byte_at(0), 32'h0000_00A1);
      check("bp_hdr_cyc",    cyc_at(0), 32'(rel));
      check("bp_data",       byte_at(1), 32'h0000_0011);
      check("bp_data_cyc",   cyc_at(1), 32'(rel + 5));
      check("bp_push_while_full", 32'(full_push_cnt), 32'd0);

      // Overrun: tick every cycle, five modules.
      do_reset();
      pre = 10'd0;
      activemods = 5'b11111;
      e_cyc = cyc;
      run(70);
      activemods = 5'b00000;
      exp_b = '{8'hBF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      check("ovr_enough_bytes", 32'(pb.size() >= 13), 32'd1);
      for (int i = 0; i < 12; i++) check("ovr_byte", byte_at(i), 32'(exp_b[i % 6]));
      check("ovr_frame3_hdr", byte_at(12), 32'h0000_00BF);
      check("ovr_hdr1_cyc", cyc_at(0), 32'(e_cyc + 2));
      check("ovr_hdr2_cyc", cyc_at(6), 32'(e_cyc + 30));
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_push_while_full", 32'(full_push_cnt), 32'd0);
      run(40);
      check("ovr_sticky", 32'(overrun), 32'd1);

      // Mask change during a frame.
      do_reset();
      pre = 10'd15;
      activemods = 5'b00011;
      e_cyc = cyc;
      run(20);
      activemods = 5'b10000;
      run(45);
      activemods = 5'b00000;
      exp_b = '{8'hA3, 8'h11, 8'h22, 8'hB0, 8'h55};
      for (int i = 0; i < 5; i++) check("mask_byte", byte_at(i), 32'(exp_b[i]));
      check("mask_hdr2_cyc", cyc_at(3), 32'(e_cyc + 33));
      run(4);

      // Reset while waiting on a silent module.
      do_reset();
      pre = 10'd3;
      silent = 5'b00001;
      activemods = 5'b00001;
      run(14);
      check("mrst_busy_before",    32'(busy),    32'd1);
      check("mrst_overrun_before", 32'(overrun), 32'd1);
      rst = 1'b1;
      #1;
      check("mrst_busy",    32'(busy),    32'd0);
      check("mrst_mod_req", 32'(mod_req), 32'd0);
      check("mrst_tx_push", 32'(tx_push), 32'd0);
      check("mrst_tx_data", 32'(tx_data), 32'd0);
      check("mrst_overrun", 32'(overrun), 32'd0);
      clear_log();
      silent = 5'b00000;
      pend_cnt = 0;
      mod_ack = 5'b00000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rel = cyc;
      run(20);
      activemods = 5'b00000;
      check("mrst_hdr",     byte_at(0), 32'h0000_00A1);
      check("mrst_hdr_cyc", cyc_at(0), 32'(rel + 5));
      check("mrst_data",    byte_at(1), 32'h0000_0011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
